rv32i_mc_control: RTL and testbench
===================================

# rv32i_mc_control

Multi-cycle control FSM for the RV32I core. It sequences instruction fetch, decode, execute, memory access and write-back. It generates the program counter write enable and next-PC select, the instruction-register load, the register-file write and the memory request strobes. It sits between the instruction register (opcode/funct3 inputs) and the datapath (PC, ALU, register file, instruction and data memories).

## Interface
- TIMEOUT, default 255: maximum wait cycles for imem_ready/dmem_ready before trapping; range 1..255.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- opcode  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12] from instruction register
- br_taken  in  1  branch comparison result from ALU, valid in EXEC
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- ir_write  out  1  load instruction register
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (qualifies dmem_req)
- pc_write  out  1  program counter write enable
- pc_src  out  2  next PC: 0=PC+4, 1=PC+imm, 2=(rs1+imm)&~1
- alu_a_sel  out  1  0=rs1, 1=PC
- alu_b_sel  out  1  0=rs2, 1=imm
- wb_sel  out  2  0=ALU, 1=load data, 2=PC+4
- rf_write  out  1  register file write enable
- trap_cause  out  2  0=none, 1=illegal, 2=timeout, 3=ECALL/EBREAK; sticky until reset
- state  out  3  current FSM state (debug)

## Operation
- States (encoding): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6–7 go to TRAP.
- Strobe outputs are combinational from state, opcode, funct3, br_taken and the ready inputs. Any strobe not listed for a state is 0.
- FETCH: imem_req=1. When imem_ready=1: ir_write=1, go to DECODE. Otherwise stay.
- DECODE: opcode is stable from the IR. Legal opcodes are 0110011, 0010011, 0110111, 0010111, 0000011, 0100011, 1100011, 1101111, 1100111, 0001111, 1110011.
  - Illegal opcode: go to TRAP with cause 1.
  - BRANCH with funct3 010 or 011: go to TRAP with cause 1.
  - SYSTEM (1110011): go to TRAP with cause 3.
  - Otherwise go to EXEC.
- EXEC, by class:
  - OP: a=rs1, b=rs2, go to WB.
  - OP-IMM, LUI: b=imm, go to WB.
  - AUIPC: a=PC, b=imm, go to WB.
  - LOAD/STORE: b=imm (address), go to MEM.
  - BRANCH: a=rs1, b=rs2; pc_write=1, pc_src=br_taken?1:0; go to FETCH.
  - JAL, JALR: go to WB.
  - FENCE: pc_write=1, pc_src=0 (no-op); go to FETCH.
- MEM: dmem_req=1, dmem_we=1 for STORE. Address operands held (b=imm).
  - On dmem_ready with LOAD: go to WB.
  - On dmem_ready with STORE: pc_write=1, pc_src=0; go to FETCH.
- WB: rf_write=1 and pc_write=1; go to FETCH.
  - JAL: wb_sel=2, pc_src=1.
  - JALR: wb_sel=2, pc_src=2.
  - LOAD: wb_sel=1, pc_src=0.
  - All others: wb_sel=0, pc_src=0.
- TRAP: all strobes 0. Remains until rst=0. trap_cause is held.
- Wait counter (8-bit):
  - Cleared on every state change.
  - Increments each cycle in FETCH or MEM while the relevant ready is 0.
  - When the counter equals TIMEOUT with ready still 0: go to TRAP with cause 2, no strobe side effects.
  - A ready arriving on the same cycle as the limit wins.

## Timing
- Reset (rst=0 at a clock edge): state=FETCH, counter=0, trap_cause=0.
  - While rst=0, every strobe output is forced to 0 combinationally.
  - The first cycle after release shows imem_req=1.
- Reset mid-operation (any state, including MEM with dmem_req high): the request drops the same cycle rst goes low. No pc_write or rf_write is issued.
- Latency with zero-wait memory:
  - OP/OP-IMM/LUI/AUIPC/JAL/JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH/FENCE: 3 cycles.
  - Each wait cycle adds 1.
- pc_write is asserted for exactly one cycle per retired instruction and never in FETCH, DECODE or TRAP.
- ir_write is asserted only in the FETCH cycle where imem_ready=1.

## Test plan
- Reset and R-type: hold rst=0 for 2 cycles, release, opcode=0110011, imem_ready=1 → strobes 0 during reset; states 0,1,2,4,0; rf_write and pc_write (pc_src=0) high only in the WB cycle; 4 cycles per instruction.
- Load with waits: opcode=0000011, dmem_ready low for 3 MEM cycles → dmem_req high for 4 cycles, dmem_we=0, then WB with wb_sel=1 and rf_write=1; 8 cycles total.
- Branch: opcode=1100011, funct3=000, br_taken=1 → EXEC pc_write=1, pc_src=1, rf_write=0. Repeat with br_taken=0 → pc_src=0. Repeat with funct3=010 → TRAP, trap_cause=1.
- JALR: opcode=1100111 → WB with wb_sel=2, pc_src=2, rf_write=1.
- Timeout: TIMEOUT=4, imem_ready held 0 → TRAP after 4 FETCH wait cycles, trap_cause=2, imem_req then 0. rst=0 recovers to FETCH with trap_cause=0.
- Reset mid-store: assert rst=0 while in MEM with dmem_req=1 → dmem_req=0 the same cycle; state=FETCH after the edge; no pc_write.

Source files
------------

// File: rtl/rv32i_mc_control.sv
// rv32i_mc_control: multi-cycle control FSM for the RV32I core.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives the datapath
// strobes. Memory waits are bounded by TIMEOUT; exceeding it traps.
//
// Ports:
//   clk, rst (sync, active-low)
//   opcode, funct3        : fields from the instruction register
//   br_taken              : branch comparison result, valid in EXEC
//   imem_ready/dmem_ready : memory handshakes
//   imem_req, ir_write, dmem_req, dmem_we, pc_write, pc_src,
//   alu_a_sel, alu_b_sel, wb_sel, rf_write : combinational strobes
//   trap_cause            : sticky trap reason (registered)
//   state                 : current FSM state (debug)
module rv32i_mc_control #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       br_taken,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_write,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic [1:0] wb_sel,
  output logic       rf_write,
  output logic [1:0] trap_cause,
  output logic [2:0] state
);

  localparam int unsigned CNT_W = 8;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
  localparam logic [1:0] CAUSE_ECALL   = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic             legal;
  logic             waiting;
  logic             at_limit;

  // State, wait counter and trap cause registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Opcode legality
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_JALR, OP_FENCE, OP_SYSTEM: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign at_limit = (cnt_q == CNT_W'(TIMEOUT));

  // Next state, trap cause and strobes
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'd0;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    wb_sel    = 2'd0;
    rf_write  = 1'b0;
    waiting   = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (at_limit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          waiting = 1'b1;
        end
      end

      S_DECODE: begin
        if (!legal) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (opcode == OP_BRANCH && (funct3 == 3'b010 || funct3 == 3'b011)) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (opcode == OP_SYSTEM) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ECALL;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (opcode)
          OP_OP: state_d = S_WB;
          OP_IMM, OP_LUI: begin
            alu_b_sel = 1'b1;
            state_d   = S_WB;
          end
          OP_AUIPC: begin
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
            state_d   = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_b_sel = 1'b1;
            state_d   = S_MEM;
          end
          OP_BRANCH: begin
            pc_write = 1'b1;
            pc_src   = br_taken ? 2'd1 : 2'd0;
            state_d  = S_FETCH;
          end
          OP_JAL, OP_JALR: state_d = S_WB;
          OP_FENCE: begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end
          // Opcode changed under us after DECODE: treat as illegal
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end

      S_MEM: begin
        dmem_req  = 1'b1;
        dmem_we   = (opcode == OP_STORE);
        alu_b_sel = 1'b1;
        if (dmem_ready) begin
          if (opcode == OP_STORE) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (at_limit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          waiting = 1'b1;
        end
      end

      S_WB: begin
        rf_write = 1'b1;
        pc_write = 1'b1;
        state_d  = S_FETCH;
        case (opcode)
          OP_JAL: begin
            wb_sel = 2'd2;
            pc_src = 2'd1;
          end
          OP_JALR: begin
            wb_sel = 2'd2;
            pc_src = 2'd2;
          end
          OP_LOAD: wb_sel = 2'd1;
          default: wb_sel = 2'd0;
        endcase
      end

      S_TRAP: state_d = S_TRAP;

      default: state_d = S_TRAP;
    endcase

    // Reset overrides every strobe immediately
    if (!rst) begin
      imem_req  = 1'b0;
      ir_write  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 2'd0;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      wb_sel    = 2'd0;
      rf_write  = 1'b0;
    end
  end

  // Wait counter: cleared on any state change, counts stalled cycles otherwise
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (waiting) begin
      cnt_d = CNT_W'(cnt_q + 8'd1);
    end
  end

  assign trap_cause = cause_q;
  assign state      = state_q;

endmodule

// File: tb/tb_rv32i_mc_control.sv
// Self-checking bench for rv32i_mc_control: an instruction-level model
// expands each instruction (class, waits, branch outcome) into the expected
// per-cycle output trace, which is then replayed against the DUT.
module tb_rv32i_mc_control;

  localparam int TO = 4;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] opcode = OP_OP;
  logic [2:0] funct3 = 3'd0;
  logic       br_taken = 1'b0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       imem_req, ir_write, dmem_req, dmem_we, pc_write;
  logic [1:0] pc_src, wb_sel, trap_cause;
  logic       alu_a_sel, alu_b_sel, rf_write;
  logic [2:0] state;

  rv32i_mc_control #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .br_taken(br_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .ir_write(ir_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .pc_write(pc_write), .pc_src(pc_src), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .wb_sel(wb_sel), .rf_write(rf_write),
    .trap_cause(trap_cause), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req;
    logic       ir_write;
    logic       dmem_req;
    logic       dmem_we;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       a_sel;
    logic       b_sel;
    logic [1:0] wb_sel;
    logic       rf_write;
    logic [1:0] cause;
  } obs_t;

  typedef struct {
    obs_t o;
    logic ir;
    logic dr;
  } step_t;

  step_t plan[$];
  int    total  = 0;
  int    passed = 0;

  function automatic obs_t sample();
    return {state, imem_req, ir_write, dmem_req, dmem_we, pc_write, pc_src,
            alu_a_sel, alu_b_sel, wb_sel, rf_write, trap_cause};
  endfunction

  function automatic obs_t quiet(logic [2:0] st, logic [1:0] cause);
    obs_t o;
    o       = '0;
    o.st    = st;
    o.cause = cause;
    return o;
  endfunction

  function automatic void add(obs_t o, logic ir, logic dr);
    step_t s;
    s.o  = o;
    s.ir = ir;
    s.dr = dr;
    plan.push_back(s);
  endfunction

  // Trap is terminal: a few cycles with both readys high must not move it
  function automatic void add_trap(logic [1:0] cause);
    for (int i = 0; i < 3; i++) add(quiet(3'd5, cause), 1'b1, 1'b1);
  endfunction

  // Instruction-level model: expected per-cycle trace of one instruction.
  // iw/dw = cycles the imem/dmem ready stays low before rising.
  function automatic void build(logic [6:0] op, logic [2:0] f3, logic br, int iw, int dw);
    obs_t o;
    bit   legal;
    bit   is_mem;
    int   n;
    legal  = op inside {OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE,
                        OP_BRANCH, OP_JAL, OP_JALR, OP_FENCE, OP_SYSTEM};
    is_mem = (op == OP_LOAD) || (op == OP_STORE);

    n = (iw > TO) ? TO + 1 : iw;
    for (int i = 0; i < n; i++) begin
      o = quiet(3'd0, 2'd0); o.imem_req = 1'b1; add(o, 1'b0, 1'b0);
    end
    if (iw > TO) begin add_trap(2'd2); return; end
    o = quiet(3'd0, 2'd0); o.imem_req = 1'b1; o.ir_write = 1'b1; add(o, 1'b1, 1'b0);

    add(quiet(3'd1, 2'd0), 1'b0, 1'b0);
    if (!legal || (op == OP_BRANCH && (f3 == 3'b010 || f3 == 3'b011))) begin
      add_trap(2'd1); return;
    end
    if (op == OP_SYSTEM) begin add_trap(2'd3); return; end

    o = quiet(3'd2, 2'd0);
    if (op == OP_IMM || op == OP_LUI || is_mem) o.b_sel = 1'b1;
    if (op == OP_AUIPC) begin o.a_sel = 1'b1; o.b_sel = 1'b1; end
    if (op == OP_BRANCH) begin o.pc_write = 1'b1; o.pc_src = br ? 2'd1 : 2'd0; end
    if (op == OP_FENCE) o.pc_write = 1'b1;
    add(o, 1'b0, 1'b0);
    if (op == OP_BRANCH || op == OP_FENCE) return;

    if (is_mem) begin
      n = (dw > TO) ? TO + 1 : dw;
      o = quiet(3'd3, 2'd0);
      o.dmem_req = 1'b1; o.dmem_we = (op == OP_STORE); o.b_sel = 1'b1;
      for (int i = 0; i < n; i++) add(o, 1'b0, 1'b0);
      if (dw > TO) begin add_trap(2'd2); return; end
      if (op == OP_STORE) o.pc_write = 1'b1;
      add(o, 1'b0, 1'b1);
      if (op == OP_STORE) return;
    end

    o = quiet(3'd4, 2'd0);
    o.rf_write = 1'b1; o.pc_write = 1'b1;
    if (op == OP_JAL)  begin o.wb_sel = 2'd2; o.pc_src = 2'd1; end
    if (op == OP_JALR) begin o.wb_sel = 2'd2; o.pc_src = 2'd2; end
    if (op == OP_LOAD) o.wb_sel = 2'd1;
    add(o, 1'b0, 1'b0);
  endfunction

  // Replays one instruction; entered and left on a falling edge
  task automatic run(input string name, input logic [6:0] op, input logic [2:0] f3,
                     input logic br, input int iw, input int dw, output bit trapped);
    obs_t got;
    plan.delete();
    build(op, f3, br, iw, dw);
    opcode = op; funct3 = f3; br_taken = br;
    foreach (plan[i]) begin
      imem_ready = plan[i].ir;
      dmem_ready = plan[i].dr;
      #1;
      got = sample();
      total++;
      if (got !== plan[i].o)
        $display("FAIL %s op=%b f3=%0d iw=%0d dw=%0d cycle %0d: got %b expected %b",
                 name, op, f3, iw, dw, i, got, plan[i].o);
      else passed++;
      @(negedge clk);
    end
    trapped = (plan[plan.size()-1].o.st == 3'd5);
  endtask

  task automatic do_reset(input string name);
    obs_t got;
    rst = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    @(negedge clk);
    #1;
    got = sample();
    total++;
    if (got !== quiet(3'd0, 2'd0))
      $display("FAIL %s reset: got %b expected %b", name, got, quiet(3'd0, 2'd0));
    else passed++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    obs_t got;
    bit   t;
    imem_ready = 1'b1; dmem_ready = 1'b1; opcode = OP_OP;
    for (int i = 0; i < 2; i++) begin
      #1;
      got = sample();
      total++;
      if (got !== quiet(3'd0, 2'd0))
        $display("FAIL reset_hold cycle %0d: got %b expected %b", i, got, quiet(3'd0, 2'd0));
      else passed++;
      @(negedge clk);
    end
    rst = 1'b1;
    run("rtype", OP_OP, 3'd0, 1'b0, 0, 0, t);
    run("rtype_b2b", OP_OP, 3'd0, 1'b0, 0, 0, t);
  endtask

  task automatic test_load_waits();
    bit t;
    run("load_wait3", OP_LOAD, 3'd2, 1'b0, 0, 3, t);
    run("store_wait2", OP_STORE, 3'd2, 1'b0, 1, 2, t);
  endtask

  task automatic test_branch();
    bit t;
    run("branch_taken", OP_BRANCH, 3'b000, 1'b1, 0, 0, t);
    run("branch_not", OP_BRANCH, 3'b000, 1'b0, 0, 0, t);
    run("branch_f3_010", OP_BRANCH, 3'b010, 1'b1, 0, 0, t);
    do_reset("branch_f3_010");
    run("branch_f3_011", OP_BRANCH, 3'b011, 1'b0, 0, 0, t);
    do_reset("branch_f3_011");
  endtask

  task automatic test_jumps();
    bit t;
    run("jalr", OP_JALR, 3'd0, 1'b0, 0, 0, t);
    run("jal", OP_JAL, 3'd0, 1'b0, 0, 0, t);
    run("auipc", OP_AUIPC, 3'd0, 1'b0, 0, 0, t);
    run("fence", OP_FENCE, 3'd0, 1'b0, 0, 0, t);
    run("ecall", OP_SYSTEM, 3'd0, 1'b0, 0, 0, t);
    do_reset("ecall");
    run("illegal", 7'b0000000, 3'd0, 1'b0, 0, 0, t);
    do_reset("illegal");
  endtask

  task automatic test_timeout();
    bit t;
    run("ready_at_limit_fetch", OP_OP, 3'd0, 1'b0, TO, 0, t);
    run("ready_at_limit_mem", OP_LOAD, 3'd0, 1'b0, 0, TO, t);
    run("timeout_fetch", OP_OP, 3'd0, 1'b0, TO + 3, 0, t);
    do_reset("timeout_fetch");
    run("after_timeout", OP_LUI, 3'd0, 1'b0, 0, 0, t);
    run("timeout_mem", OP_STORE, 3'd0, 1'b0, 0, TO + 1, t);
    do_reset("timeout_mem");
  endtask

  task automatic test_reset_mid_store();
    obs_t got;
    bit   t;
    plan.delete();
    build(OP_STORE, 3'd2, 1'b0, 0, 3);
    opcode = OP_STORE; funct3 = 3'd2; br_taken = 1'b0;
    foreach (plan[i]) begin
      imem_ready = plan[i].ir;
      dmem_ready = plan[i].dr;
      #1;
      got = sample();
      total++;
      if (got !== plan[i].o)
        $display("FAIL mid_store lead cycle %0d: got %b expected %b", i, got, plan[i].o);
      else passed++;
      if (plan[i].o.st == 3'd3) break;
      @(negedge clk);
    end
    // Drop reset while dmem_req is high: strobes must fall in this same cycle
    rst = 1'b0;
    #1;
    got = sample();
    total++;
    if (got !== quiet(3'd3, 2'd0))
      $display("FAIL mid_store drop: got %b expected %b", got, quiet(3'd3, 2'd0));
    else passed++;
    @(negedge clk);
    #1;
    got = sample();
    total++;
    if (got !== quiet(3'd0, 2'd0))
      $display("FAIL mid_store after_edge: got %b expected %b", got, quiet(3'd0, 2'd0));
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    run("after_mid_store", OP_STORE, 3'd2, 1'b0, 0, 0, t);
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [11];
    logic [6:0] op;
    int         r, iw, dw;
    bit         t;
    ops = '{OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR, OP_FENCE, OP_SYSTEM};
    for (int k = 0; k < 60; k++) begin
      r  = int'($urandom_range(0, 12));
      op = (r < 11) ? ops[r] : 7'($urandom);
      iw = ($urandom_range(0, 9) == 0) ? TO + 1 : int'($urandom_range(0, TO));
      dw = ($urandom_range(0, 9) == 0) ? TO + 1 : int'($urandom_range(0, TO));
      run("random", op, 3'($urandom), 1'($urandom), iw, dw, t);
      if (t) do_reset("random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_load_waits();
    test_branch();
    test_jumps();
    test_timeout();
    test_reset_mid_store();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
